bar_sel_arb: RTL and testbench

//  Parametrised successor to the fixed three-input bar leaf. NCH input channels of
//  DW bits each are filtered by a static channel mask and a runtime channel mask.

---
 rtl/bar_sel_pkg.sv | 22 ++
 rtl/bar_sel_arb_if.sv | 40 ++++
 rtl/bar_rr_arb.sv | 56 +++++
 rtl/bar_sel_arb.sv | 104 ++++++++++
 tb/tb_bar_sel_arb.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bar_sel_pkg.sv
// Shared helpers and defaults for the masked round-robin channel selector.
// Imported by the interface, the arbiter and the top level.
package bar_sel_pkg;

    // Width of an index able to address n items; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int unsigned NCH_DEF = 3;
    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned DCW_DEF = 16;
    localparam int unsigned CW_DEF  = clog2(NCH_DEF);

    typedef logic [CW_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/bar_sel_arb_if.sv
// Channel-side and consumer-side handshake bundle of bar_sel_arb.
// master = producers/consumer around the block, slave = the selector itself.
interface bar_sel_arb_if
    import bar_sel_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned DW  = DW_DEF
) ();

    localparam int unsigned CW = clog2(NCH);

    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );

endinterface

// File: rtl/bar_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last granted channel.
// The pointer only moves when a grant is actually taken (advance with a request).
module bar_rr_arb
    import bar_sel_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned CW  = clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  grant_idx
);

    logic [CW-1:0] rr_last_q, rr_last_d;
    logic [CW-1:0] idx;
    logic          found;

    // Search order rr_last+1, rr_last+2, ... wrapping at NCH-1 back to 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = CW'((32'(rr_last_q) + k) % NCH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (advance && found) begin
            rr_last_d = grant_idx;
        end
    end

    // Reset to the top index so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= CW'(NCH - 1);
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    grant_onehot_a : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    grant_in_req_a : assert property (@(posedge clk) disable iff (reset) (grant & ~req) == '0);

endmodule

// File: rtl/bar_sel_arb.sv
// Masked round-robin selector of NCH producer channels into one registered stream.
// Beats on masked channels are accepted and discarded, counted in a saturating counter.
module bar_sel_arb
    import bar_sel_pkg::*;
#(
    parameter int unsigned    NCH     = NCH_DEF,
    parameter int unsigned    DW      = DW_DEF,
    parameter logic [NCH-1:0] CH_MASK = 3'b011,
    parameter int unsigned    DCW     = DCW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     en_mask,
    bar_sel_arb_if.slave       bus,
    output logic [DCW-1:0]     drop_cnt
);

    localparam int unsigned CW = clog2(NCH);

    logic [NCH-1:0] eff_mask;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] dropped;
    logic [CW-1:0]  grant_idx;
    logic           load;
    logic           any_elig;

    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  data_q, data_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [DCW-1:0] drop_q, drop_d;
    logic [CW:0]    drop_pop;
    logic [DCW:0]   drop_sum;

    assign eff_mask = CH_MASK & en_mask;
    assign elig     = bus.in_valid & eff_mask;
    assign any_elig = |elig;
    assign load     = ~out_valid_q | bus.out_ready;
    assign dropped  = bus.in_valid & ~eff_mask;

    bar_rr_arb #(
        .NCH (NCH),
        .CW  (CW)
    ) u_rr_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (elig),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Masked channels are always ready so their beats drain as drops.
    assign bus.in_ready = ~eff_mask | ({NCH{load}} & grant);

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        ch_d        = ch_q;
        if (load) begin
            out_valid_d = any_elig;
            if (any_elig) begin
                ch_d = grant_idx;
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (grant[i]) begin
                        data_d = bus.in_data[i*DW +: DW];
                    end
                end
            end
        end
    end

    always_comb begin
        drop_pop = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            drop_pop = drop_pop + (CW+1)'(dropped[i]);
        end
        drop_sum = {1'b0, drop_q} + (DCW+1)'(drop_pop);
        drop_d   = drop_sum[DCW] ? {DCW{1'b1}} : drop_sum[DCW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            ch_q        <= '0;
            drop_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign drop_cnt      = drop_q;

    stall_hold_a : assert property (@(posedge clk) disable iff (reset)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(data_q) && $stable(ch_q)));

endmodule

// File: tb/tb_bar_sel_arb.sv
// Self-checking bench for bar_sel_arb: reference model feeds a scoreboard of expected
// output words; directed sequences cover masking, stalls, saturation and mid-stall reset.
module tb_bar_sel_arb;
    import bar_sel_pkg::*;

    localparam logic [2:0] TB_CH_MASK = 3'b011;

    typedef struct packed {
        ch_idx_t    ch;
        logic [7:0] data;
    } sb_entry_t;

    logic        clk;
    logic        reset;
    logic [2:0]  en_mask;
    logic [15:0] drop_cnt;

    bar_sel_arb_if #(.NCH(3), .DW(8)) bus ();

    bar_sel_arb #(
        .NCH     (3),
        .DW      (8),
        .CH_MASK (TB_CH_MASK),
        .DCW     (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en_mask  (en_mask),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_checks;
    int        n_errors;
    sb_entry_t sb[$];

    logic m_valid;
    int   m_rr;
    int   m_drop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: check settled outputs against the model, advance model, cross the edge.
    task automatic tick();
        logic [2:0] eff, elig, grant_m, exp_rdy;
        logic       load;
        int         gi, idx, pop;
        sb_entry_t  e;
        #1;
        check_eq("out_valid", bus.out_valid, m_valid);
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq("sb_out_ch", bus.out_ch, e.ch);
                check_eq("sb_out_data", bus.out_data, e.data);
            end
        end
        eff  = TB_CH_MASK & en_mask;
        elig = bus.in_valid & eff;
        load = !m_valid || bus.out_ready;
        gi   = -1;
        for (int k = 1; k <= 3; k++) begin
            idx = (m_rr + k) % 3;
            if (gi < 0 && elig[idx]) gi = idx;
        end
        grant_m = (gi >= 0) ? 3'(1 << gi) : 3'b000;
        exp_rdy = ~eff | (load ? grant_m : 3'b000);
        check_eq("in_ready", bus.in_ready, exp_rdy);
        if (reset) begin
            m_valid = 1'b0;
            m_rr    = 2;
            m_drop  = 0;
            sb.delete();
        end else begin
            if (load) begin
                m_valid = (gi >= 0);
                if (gi >= 0) begin
                    e.ch   = ch_idx_t'(gi);
                    e.data = bus.in_data[gi*8 +: 8];
                    sb.push_back(e);
                    m_rr = gi;
                end
            end
            pop    = $countones(bus.in_valid & ~eff);
            m_drop = (m_drop + pop > 65535) ? 65535 : m_drop + pop;
        end
        @(posedge clk);
        #1;
        check_eq("drop_cnt", drop_cnt, m_drop);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        en_mask       = 3'b111;
        bus.in_valid  = 3'b000;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        m_valid       = 1'b0;
        m_rr          = 2;
        m_drop        = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_ch", bus.out_ch, 2'd0);
        check_eq("rst_out_data", bus.out_data, 8'h00);
        check_eq("rst_drop_cnt", drop_cnt, 16'h0000);

        // Alternation between the two statically enabled channels
        bus.in_valid = 3'b011;
        for (int k = 0; k < 6; k++) begin
            bus.in_data = 24'($urandom);
            tick();
            check_eq("t1_out_ch", bus.out_ch, 2'(k % 2));
        end
        check_eq("t1_drop", drop_cnt, 16'd0);

        // Statically masked channel drains as drops
        bus.in_valid = 3'b100;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t2_rdy2", bus.in_ready[2], 1'b1);
        end
        check_eq("t2_drop", drop_cnt, 16'd5);

        // Stall holds the word and blocks unmasked channels
        bus.in_valid  = 3'b011;
        bus.in_data   = {8'h33, 8'h5C, 8'hA5};
        bus.out_ready = 1'b0;
        tick();
        check_eq("t3_first_ch", bus.out_ch, 2'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t3_stall_data", bus.out_data, 8'hA5);
            check_eq("t3_stall_ch", bus.out_ch, 2'd0);
            check_eq("t3_stall_rdy", bus.in_ready[1:0], 2'b00);
        end
        bus.out_ready = 1'b1;
        tick();
        check_eq("t3_release_ch", bus.out_ch, 2'd1);
        check_eq("t3_release_data", bus.out_data, 8'h5C);
        bus.in_valid = 3'b000;
        tick();

        // Reset while a ch1 word is stalled
        bus.in_valid  = 3'b010;
        bus.in_data   = {8'h11, 8'h77, 8'h22};
        bus.out_ready = 1'b0;
        tick();
        check_eq("t5_pending_ch", bus.out_ch, 2'd1);
        bus.in_valid = 3'b000;
        tick();
        reset = 1'b1;
        tick();
        check_eq("t5_rst_valid", bus.out_valid, 1'b0);
        reset         = 1'b0;
        bus.in_valid  = 3'b011;
        bus.out_ready = 1'b1;
        tick();
        check_eq("t5_first_ch", bus.out_ch, 2'd0);

        // Runtime mask fully closed, then reopened
        en_mask = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t6_no_valid", bus.out_valid, 1'b0);
        end
        check_eq("t6_drop", drop_cnt, 16'd6);
        en_mask = 3'b111;
        tick();
        check_eq("t6_regrant", bus.out_valid, 1'b1);

        // Saturation of the drop counter
        bus.in_valid = 3'b000;
        reset        = 1'b1;
        tick();
        reset   = 1'b0;
        en_mask = 3'b000;
        bus.in_valid = 3'b111;
        for (int k = 0; k < 21844; k++) begin
            tick();
        end
        bus.in_valid = 3'b011;
        tick();
        check_eq("t4_fffe", drop_cnt, 16'hFFFE);
        bus.in_valid = 3'b111;
        tick();
        check_eq("t4_sat", drop_cnt, 16'hFFFF);
        tick();
        check_eq("t4_sat_hold", drop_cnt, 16'hFFFF);
        bus.in_valid = 3'b000;
        tick();
        check_eq("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
